// File: rtl/vram_sys_arb.sv
// rtl/vram_sys_arb.sv - VRAM system-port arbiter: CPU access FSM plus constant-word fill engine (fill built only when VRAM_FILL_EN is defined)
module vram_sys_arb #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_wen,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_addr,
  input  logic [LEN_WIDTH-1:0]  fill_len,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] addr_sys,
  output logic [DATA_WIDTH-1:0] in_sys,
  output logic                  wen,
  input  logic [DATA_WIDTH-1:0] out_sys
);

  typedef enum logic {IDLE = 1'b0, CPU_ACK = 1'b1} state_t;

  state_t                state;
  logic                  ack_is_read;
  logic                  cpu_grant;
  logic                  fill_grant;
  logic [ADDR_WIDTH-1:0] fill_wr_addr;
  logic [DATA_WIDTH-1:0] fill_wr_data;

  // The CPU wins the port whenever it asks from IDLE; the ack cycle leaves the port to the fill.
  assign cpu_grant = !rst && (state == IDLE) && cpu_req;

  // CPU handshake: grant in IDLE, acknowledge exactly one cycle later, then back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ack_is_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            state       <= CPU_ACK;
            ack_is_read <= !cpu_wen;
          end
        end
        CPU_ACK: begin
          state       <= IDLE;
          ack_is_read <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          ack_is_read <= 1'b0;
        end
      endcase
    end
  end

  // rst gates the ack so a reset landing on the ack cycle drops it immediately.
  assign cpu_ack   = !rst && (state == CPU_ACK);
  assign cpu_rdata = (cpu_ack && ack_is_read) ? out_sys : '0;

`ifdef VRAM_FILL_EN
  localparam int PTR_WIDTH = ADDR_WIDTH - 2;

  logic                 busy_q;
  logic                 done_q;
  logic [PTR_WIDTH-1:0] ptr_q;
  logic [LEN_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                 unused_fill_addr_lo;

  // Fill targets whole words, so the byte offset is dropped.
  assign unused_fill_addr_lo = ^fill_addr[1:0];
  assign fill_grant          = !rst && !cpu_grant && busy_q;

  // Fill engine: latch job on an idle start, then one word per granted cycle until the count runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q && fill_start) begin
        ptr_q  <= fill_addr[ADDR_WIDTH-1:2];
        cnt_q  <= fill_len;
        data_q <= fill_data;
        if (fill_len == '0) begin
          done_q <= 1'b1;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (fill_grant) begin
        ptr_q <= ptr_q + PTR_WIDTH'(1);
        cnt_q <= cnt_q - LEN_WIDTH'(1);
        if (cnt_q == LEN_WIDTH'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign fill_wr_addr = {ptr_q, 2'b00};
  assign fill_wr_data = data_q;
  assign fill_busy    = !rst && busy_q;
  assign fill_done    = !rst && done_q;
`else
  logic unused_fill;

  // Without the fill engine the fill inputs are deliberately ignored.
  assign unused_fill  = ^{fill_start, fill_addr, fill_len, fill_data};
  assign fill_grant   = 1'b0;
  assign fill_wr_addr = '0;
  assign fill_wr_data = '0;
  assign fill_busy    = 1'b0;
  assign fill_done    = 1'b0;
`endif

  // VRAM port mux driven straight from this cycle's grant.
  always_comb begin
    addr_sys = '0;
    in_sys   = '0;
    wen      = 1'b0;
    if (cpu_grant) begin
      addr_sys = cpu_addr;
      in_sys   = cpu_wdata;
      wen      = cpu_wen;
    end else if (fill_grant) begin
      addr_sys = fill_wr_addr;
      in_sys   = fill_wr_data;
      wen      = 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_sys_arb.sv
// tb/tb_vram_sys_arb.sv - self-checking bench for vram_sys_arb with VRAM model and reference memory
module tb_vram_sys_arb;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 11;
  localparam int NW = 2048;
`ifdef VRAM_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0;
  logic          cpu_wen = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_addr = '0;
  logic [LW-1:0] fill_len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] addr_sys;
  logic [DW-1:0] in_sys;
  logic          wen;
  logic [DW-1:0] out_sys = '0;
  logic          do_init = 1'b1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
    bit            ack;
  } wr_t;

  typedef struct {
    bit            w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  wr_t           wr_q[$];
  int            done_q[$];
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] vmem[NW];
  logic [DW-1:0] ref_mem[NW];

  vram_sys_arb dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len), .fill_data(fill_data),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .addr_sys(addr_sys), .in_sys(in_sys), .wen(wen), .out_sys(out_sys)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < NW; i++) vmem[i] <= init_val(i);
    end else if (wen) begin
      vmem[addr_sys[AW-1:2]] <= in_sys;
    end
    out_sys <= vmem[addr_sys[AW-1:2]];
  end

  always @(negedge clk) begin
    if (wen) wr_q.push_back('{addr_sys, in_sys, cyc, cpu_ack});
    if (fill_done) done_q.push_back(cyc);
    if (!cpu_ack) chk("rdata_without_ack", cpu_rdata, 0);
  end

  task automatic cpu_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd);
    @(posedge clk); #1;
    fill_start = 1'b0;
    cpu_req = 1'b1; cpu_wen = w; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    chk("grant_addr", addr_sys, a);
    chk("grant_wen", wen, w);
    if (w) chk("grant_wdata", in_sys, d);
    chk("grant_no_ack", cpu_ack, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ack_latency", cpu_ack, 1);
    rd = cpu_rdata;
  endtask

  task automatic fill_go(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d);
    @(posedge clk); #1;
    fill_start = 1'b1; fill_addr = a; fill_len = LW'(len); fill_data = d;
  endtask

  task automatic wait_fill(input int dbase, input int limit);
    int t = 0;
    while (done_q.size() == dbase && t < limit) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ack"}, cpu_ack, 0);
    chk({tag, "_rdata"}, cpu_rdata, 0);
    chk({tag, "_wen"}, wen, 0);
    chk({tag, "_addr"}, addr_sys, 0);
    chk({tag, "_insys"}, in_sys, 0);
    chk({tag, "_busy"}, fill_busy, 0);
    chk({tag, "_done"}, fill_done, 0);
  endtask

  initial begin
    vec_t          vt[8];
    logic [DW-1:0] rd;
    int            base, dbase, k, bad;
    int            exp_words[4];

    vt[0] = '{1'b0, 13'h0014, 32'h0, 32'hDEADBEEF};
    vt[1] = '{1'b1, 13'h0020, 32'h12345678, 32'h0};
    vt[2] = '{1'b0, 13'h0020, 32'h0, 32'h12345678};
    vt[3] = '{1'b1, 13'h0023, 32'hCAFEF00D, 32'h0};
    vt[4] = '{1'b0, 13'h0020, 32'h0, 32'hCAFEF00D};
    vt[5] = '{1'b0, 13'h0000, 32'h0, 32'hC0DE0000};
    vt[6] = '{1'b1, 13'h1FFC, 32'h0BADF00D, 32'h0};
    vt[7] = '{1'b0, 13'h1FFE, 32'h0, 32'h0BADF00D};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0; do_init = 1'b0;

    // table-driven CPU accesses
    for (int i = 0; i < 8; i++) begin
      cpu_op(vt[i].w, vt[i].addr, vt[i].wdata, rd);
      if (!vt[i].w) chk($sformatf("table_read_%0d", i), rd, vt[i].exp);
      @(posedge clk); #1;
      cpu_req = 1'b0;
    end

    // fill wrapping past the top of VRAM
    base = wr_q.size(); dbase = done_q.size();
    fill_go(13'h1FF8, 4, 32'hA5A5A5A5);
    @(negedge clk);
    chk("fill_busy_start_cycle", fill_busy, 0);
    @(posedge clk); #1;
    fill_start = 1'b0;
    @(negedge clk);
    chk("fill_busy_next_cycle", fill_busy, FILL_ON);
    wait_fill(dbase, 100);
    chk("wrap_nwrites", wr_q.size() - base, FILL_ON ? 4 : 0);
    exp_words = '{2046, 2047, 0, 1};
    for (int i = base; i < wr_q.size() && i < base + 4; i++) begin
      chk("wrap_addr", wr_q[i].addr, exp_words[i - base] * 4);
      chk("wrap_data", wr_q[i].data, 32'hA5A5A5A5);
    end
    chk("wrap_done_count", done_q.size() - dbase, FILL_ON);
    if (done_q.size() > dbase && wr_q.size() > base)
      chk("wrap_done_timing", done_q[dbase], wr_q[wr_q.size() - 1].cyc + 1);
    @(posedge clk); #1;
    chk("wrap_word2", vmem[2], init_val(2));
    chk("wrap_word2047", vmem[2047], FILL_ON ? 32'hA5A5A5A5 : 32'h0BADF00D);

    // fill alongside a CPU holding cpu_req high
    base = wr_q.size(); dbase = done_q.size();
    fill_go(13'h0400, 8, 32'h5A5A1234);
    for (int j = 0; j < 4; j++) begin
      cpu_op(1'b1, AW'(160 + 4 * j), 32'h77000000 + 32'(j), rd);
      cpu_op(1'b0, AW'(160 + 4 * j), 32'h0, rd);
      chk("held_read", rd, 32'h77000000 + 32'(j));
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    wait_fill(dbase, 50);
    k = 0; bad = 0;
    for (int i = base; i < wr_q.size(); i++) begin
      if (wr_q[i].addr >= 13'h0400 && wr_q[i].addr < 13'h0420) begin
        if (wr_q[i].addr != AW'(13'h0400 + 4 * k) || !wr_q[i].ack) bad++;
        k++;
      end
    end
    chk("held_fill_writes", k, FILL_ON ? 8 : 0);
    chk("held_fill_order_alternate", bad, 0);
    chk("held_done_count", done_q.size() - dbase, FILL_ON);

    // zero-length fill
    base = wr_q.size();
    fill_go(13'h0800, 0, 32'h11111111);
    @(posedge clk); #1;
    fill_start = 1'b0;
    @(negedge clk);
    chk("len0_done", fill_done, FILL_ON);
    chk("len0_busy", fill_busy, 0);
    repeat (5) @(negedge clk);
    chk("len0_nwrites", wr_q.size() - base, 0);

    // second start while busy is ignored
    base = wr_q.size(); dbase = done_q.size();
    fill_go(13'h0800, 5, 32'h22222222);
    @(posedge clk); #1;
    fill_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fill_start = 1'b1; fill_addr = 13'h0960; fill_len = LW'(3); fill_data = 32'h33333333;
    @(posedge clk); #1;
    fill_start = 1'b0;
    wait_fill(dbase, 50);
    repeat (4) @(negedge clk);
    chk("restart_nwrites", wr_q.size() - base, FILL_ON ? 5 : 0);
    for (int i = base; i < wr_q.size(); i++) begin
      chk("restart_addr", wr_q[i].addr, AW'(13'h0800 + 4 * (i - base)));
      chk("restart_data", wr_q[i].data, 32'h22222222);
    end
    chk("restart_done_count", done_q.size() - dbase, FILL_ON);

    // reset on the third write of a six-word fill
    base = wr_q.size(); dbase = done_q.size();
    fill_go(13'h0C00, 6, 32'h77777777);
    @(posedge clk); #1;
    fill_start = 1'b0;
    k = 0;
    while (wr_q.size() - base < 2 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rst_mid_fill");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("after_rst");
    repeat (8) @(negedge clk);
    chk("rst_fill_nwrites", wr_q.size() - base, FILL_ON ? 2 : 0);
    chk("rst_fill_no_done", done_q.size() - dbase, 0);
    chk("rst_word769", vmem[769], FILL_ON ? 32'h77777777 : init_val(769));
    chk("rst_word770", vmem[770], init_val(770));

    // reset on a CPU ack cycle
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 13'h0014;
    @(posedge clk); #1;
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_on_ack_ack", cpu_ack, 0);
    chk("rst_on_ack_rdata", cpu_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_op(1'b0, 13'h0014, 32'h0, rd);
    chk("read_after_rst", rd, 32'hDEADBEEF);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // randomized fills with concurrent CPU traffic against a reference memory
    @(posedge clk); #1;
    do_init = 1'b1;
    @(posedge clk); #1;
    do_init = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
    for (int it = 0; it < 20; it++) begin
      int            w0, len, nops, gap, word;
      logic [DW-1:0] d, dd;
      logic [AW-1:0] a;
      bit            w;
      w0 = 1024 + $urandom_range(0, 899);
      len = $urandom_range(0, 99);
      d = $urandom;
      base = wr_q.size(); dbase = done_q.size();
      fill_go(AW'(w0 * 4 + $urandom_range(0, 3)), len, d);
      nops = $urandom_range(5, 30);
      for (int n = 0; n < nops; n++) begin
        gap = $urandom_range(0, 2);
        if (gap > 0) begin
          @(posedge clk); #1;
          cpu_req = 1'b0; fill_start = 1'b0;
          repeat (gap - 1) @(posedge clk);
        end
        word = $urandom_range(0, 255);
        w = 1'($urandom_range(0, 1));
        a = AW'(word * 4 + $urandom_range(0, 3));
        dd = $urandom;
        cpu_op(w, a, dd, rd);
        if (w) ref_mem[word] = dd;
        else chk("rand_cpu_read", rd, ref_mem[word]);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; fill_start = 1'b0;
      wait_fill(dbase, 400);
      chk("rand_done_count", done_q.size() - dbase, FILL_ON);
      if (FILL_ON) for (int i = 0; i < len; i++) ref_mem[w0 + i] = d;
      k = 0;
      for (int i = base; i < wr_q.size(); i++) begin
        if (wr_q[i].addr >= AW'(1024 * 4)) begin
          chk("rand_fill_addr", wr_q[i].addr, AW'((w0 + k) * 4));
          chk("rand_fill_data", wr_q[i].data, d);
          k++;
        end
      end
      chk("rand_fill_nwrites", k, FILL_ON ? len : 0);
    end
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < NW; i++) if (vmem[i] !== ref_mem[i]) bad++;
    chk("rand_mem_image", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
